multi_edge_detect: RTL and testbench

MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

---
 rtl/multi_edge_detect_pkg.sv | 32 +++
 rtl/edge_detect_chan.sv | 103 ++++++++++
 rtl/multi_edge_detect.sv | 58 +++++
 tb/tb_multi_edge_detect.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_edge_detect_pkg.sv
// Shared definitions for multi_edge_detect: per-channel mode encodings,
// parameter range limits and the mode/edge selection helper.
package multi_edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int WIDTH_MIN       = 1;
  localparam int WIDTH_MAX       = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEB_CYCLES_MIN  = 2;
  localparam int DEB_CYCLES_MAX  = 255;

  // True when the detected edge is one the channel's mode asks to report.
  function automatic logic mode_hit(input mode_e mode, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_detect_chan.sv
// One edge-detect channel: synchroniser, optional debounce filter
// (MULTI_EDGE_DEBOUNCE_EN), edge pulses, mode-selected event, sticky status/overflow.
module edge_detect_chan
  import multi_edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig,
  input  logic [1:0] mode,
  input  logic       clr,
  output logic       pos_edge,
  output logic       neg_edge,
  output logic       evt,
  output logic       status,
  output logic       ovf
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
    $error("edge_detect_chan: SYNC_STAGES out of range");
  end
  if (DEB_CYCLES < DEB_CYCLES_MIN || DEB_CYCLES > DEB_CYCLES_MAX) begin : g_bad_deb_cycles
    $error("edge_detect_chan: DEB_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level;
  logic                   det_level;
  logic                   hist_reg;
  logic                   pos_reg;
  logic                   neg_reg;
  logic                   evt_reg;
  logic                   status_reg;
  logic                   ovf_reg;
  logic                   rise_next;
  logic                   fall_next;
  logic                   evt_next;

  assign level = sync_reg[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             filt_reg;

  // The filtered level only follows the synchroniser after DEB_CYCLES
  // consecutive disagreeing samples; any agreement restarts the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b0;
    end else if (level == filt_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
      filt_reg <= level;
      cnt_reg  <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign det_level = filt_reg;
`else
  assign det_level = level;
`endif

  always_comb begin
    rise_next = det_level & ~hist_reg;
    fall_next = ~det_level & hist_reg;
    evt_next  = mode_hit(mode_e'(mode), rise_next, fall_next);
  end

  // Status and overflow share the set-wins-over-clear rule.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg   <= '0;
      hist_reg   <= 1'b0;
      pos_reg    <= 1'b0;
      neg_reg    <= 1'b0;
      evt_reg    <= 1'b0;
      status_reg <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], sig};
      hist_reg   <= det_level;
      pos_reg    <= rise_next;
      neg_reg    <= fall_next;
      evt_reg    <= evt_next;
      status_reg <= evt_next | (status_reg & ~clr);
      ovf_reg    <= (evt_next & status_reg) | (ovf_reg & ~clr);
    end
  end

  assign pos_edge = pos_reg;
  assign neg_edge = neg_reg;
  assign evt      = evt_reg;
  assign status   = status_reg;
  assign ovf      = ovf_reg;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector with sticky status and a shared interrupt.
// Optional per-channel debounce filter enabled by MULTI_EDGE_DEBOUNCE_EN.
module multi_edge_detect
  import multi_edge_detect_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   signal_in,
  input  logic [2*WIDTH-1:0] mode_i,
  input  logic [WIDTH-1:0]   irq_en_i,
  input  logic [WIDTH-1:0]   clr_i,
  output logic [WIDTH-1:0]   pos_edge,
  output logic [WIDTH-1:0]   neg_edge,
  output logic [WIDTH-1:0]   event_o,
  output logic [WIDTH-1:0]   status_o,
  output logic [WIDTH-1:0]   ovf_o,
  output logic               irq_o
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("multi_edge_detect: WIDTH out of range");
  end

  logic irq_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    edge_detect_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sig      (signal_in[gi]),
      .mode     (mode_i[2*gi +: 2]),
      .clr      (clr_i[gi]),
      .pos_edge (pos_edge[gi]),
      .neg_edge (neg_edge[gi]),
      .evt      (event_o[gi]),
      .status   (status_o[gi]),
      .ovf      (ovf_o[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |(status_o & irq_en_i);
    end
  end

  assign irq_o = irq_reg;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Self-checking bench for multi_edge_detect: directed scenarios plus random
// traffic, every cycle compared against a behavioural model.
module tb_multi_edge_detect;

  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 4;
`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int LAT = S + 1 + D;
`else
  localparam int LAT = S + 1;
`endif
  localparam int HN = 4096;

  logic           clk;
  logic           rst;
  logic [W-1:0]   signal_in;
  logic [2*W-1:0] mode_i;
  logic [W-1:0]   irq_en_i;
  logic [W-1:0]   clr_i;
  logic [W-1:0]   pos_edge;
  logic [W-1:0]   neg_edge;
  logic [W-1:0]   event_o;
  logic [W-1:0]   status_o;
  logic [W-1:0]   ovf_o;
  logic           irq_o;

  multi_edge_detect #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .DEB_CYCLES  (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .signal_in (signal_in),
    .mode_i    (mode_i),
    .irq_en_i  (irq_en_i),
    .clr_i     (clr_i),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .event_o   (event_o),
    .status_o  (status_o),
    .ovf_o     (ovf_o),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model history, indexed by edge number: sampled input, synchronised level,
  // level used for edge detection (filtered when debounce is built in).
  bit [W-1:0] in_s [HN];
  bit [W-1:0] lvl  [HN];
  bit [W-1:0] det  [HN];
  int k = 32;
  bit [W-1:0] e_pos, e_neg, e_ev, e_st, e_ov;
  bit         e_irq;

  function automatic int ix(input int n);
    return n & (HN - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit [W-1:0] rise, fall, ev;
    bit all_diff;
    k++;
    if (rst) begin
      in_s[ix(k)] = '0;
      lvl[ix(k)]  = '0;
      det[ix(k)]  = '0;
      e_pos = '0; e_neg = '0; e_ev = '0; e_st = '0; e_ov = '0; e_irq = 1'b0;
    end else begin
      in_s[ix(k)] = signal_in;
      lvl[ix(k)]  = in_s[ix(k - S + 1)];
`ifdef MULTI_EDGE_DEBOUNCE_EN
      det[ix(k)] = det[ix(k-1)];
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= D; j++)
          if (lvl[ix(k-j)][b] == det[ix(k-1)][b]) all_diff = 1'b0;
        if (all_diff) det[ix(k)][b] = ~det[ix(k-1)][b];
      end
`else
      all_diff = 1'b0;
      det[ix(k)] = lvl[ix(k)];
`endif
      rise = det[ix(k-1)] & ~det[ix(k-2)];
      fall = ~det[ix(k-1)] & det[ix(k-2)];
      for (int b = 0; b < W; b++) begin
        case (mode_i[2*b +: 2])
          2'b01:   ev[b] = rise[b];
          2'b10:   ev[b] = fall[b];
          2'b11:   ev[b] = rise[b] | fall[b];
          default: ev[b] = 1'b0;
        endcase
      end
      e_irq = |(e_st & irq_en_i);
      e_ov  = (ev & e_st) | (e_ov & ~clr_i);
      e_st  = ev | (e_st & ~clr_i);
      e_ev  = ev;
      e_pos = rise;
      e_neg = fall;
    end
  endtask

  task automatic check_all();
    chk("pos_edge", pos_edge, e_pos);
    chk("neg_edge", neg_edge, e_neg);
    chk("event_o",  event_o,  e_ev);
    chk("status_o", status_o, e_st);
    chk("ovf_o",    ovf_o,    e_ov);
    chk("irq_o",    irq_o,    e_irq);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset: outputs must drop at once, then n clocked edges in reset.
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int j = 0; j < 16; j++) begin
      k++;
      in_s[ix(k)] = '0; lvl[ix(k)] = '0; det[ix(k)] = '0;
    end
    e_pos = '0; e_neg = '0; e_ev = '0; e_st = '0; e_ov = '0; e_irq = 1'b0;
    #1;
    check_all();
    repeat (n) step();
  endtask

  initial begin
    bit [W-1:0] mask;
    rst = 1'b1; signal_in = '0; mode_i = '0; irq_en_i = '0; clr_i = '0;
    @(posedge clk); #1;
    do_reset(3);
    chk("reset_all_zero", {pos_edge, neg_edge, event_o, status_o, ovf_o, 7'd0, irq_o}, 0);
    rst = 1'b0;

    // Rise on ch0 in fall-only mode: pos_edge at LAT, no event.
    mode_i = 16'h0002; irq_en_i = 8'h01;
    signal_in[0] = 1'b1;
    for (int e = 1; e <= LAT + 1; e++) begin
      step();
      chk("s1_pos0", pos_edge[0], (e == LAT));
      chk("s1_neg0", neg_edge[0], 0);
      chk("s1_evt0", event_o[0], 0);
    end

    // Fall on ch0: event, status, then irq one cycle later.
    signal_in[0] = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      step();
      chk("s2_evt0", event_o[0], (e == LAT));
      if (e == LAT) begin
        chk("s2_status0", status_o[0], 1);
        chk("s2_irq_before", irq_o, 0);
      end
      if (e == LAT + 1) chk("s2_irq", irq_o, 1);
    end
    clr_i = 8'h01; step(); clr_i = '0;
    chk("s2_clr_status0", status_o[0], 0);
    step();
    chk("s2_clr_irq", irq_o, 0);

    // Overflow on ch3, then clear colliding with a third event.
    mode_i = 16'h00C2;
    signal_in[3] = 1'b1; repeat (LAT + 1) step();
    chk("s3_status3", status_o[3], 1);
    chk("s3_ovf3_first", ovf_o[3], 0);
    signal_in[3] = 1'b0; repeat (LAT + 1) step();
    chk("s3_ovf3", ovf_o[3], 1);
    signal_in[3] = 1'b1; repeat (LAT - 1) step();
    clr_i = 8'h08; step(); clr_i = '0;
    chk("s3_evt3_collide", event_o[3], 1);
    chk("s3_status3_kept", status_o[3], 1);
    chk("s3_ovf3_kept", ovf_o[3], 1);
    clr_i = 8'h08; step(); clr_i = '0;
    chk("s3_status3_clr", status_o[3], 0);
    chk("s3_ovf3_clr", ovf_o[3], 0);

    // Mode 11 -> 00 on ch2 keeps status; later edges pulse but make no event.
    mode_i = 16'h00F2;
    signal_in[2] = 1'b1; repeat (LAT + 1) step();
    chk("s6_status2", status_o[2], 1);
    mode_i = 16'h00C2; step();
    chk("s6_status2_hold", status_o[2], 1);
    signal_in[2] = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      step();
      chk("s6_neg2", neg_edge[2], (e == LAT));
      chk("s6_evt2", event_o[2], 0);
    end
    chk("s6_status2_end", status_o[2], 1);
    chk("s6_ovf2_end", ovf_o[2], 0);

    // Ch4 toggling every cycle.
    for (int e = 0; e < 12; e++) begin
      signal_in[4] = ~signal_in[4];
      step();
    end
    signal_in[4] = 1'b0;
    repeat (LAT + 2) step();

`ifdef MULTI_EDGE_DEBOUNCE_EN
    // Debounce: short pulse filtered out, long pulse passes at LAT.
    signal_in[1] = 1'b1; repeat (3) step(); signal_in[1] = 1'b0;
    for (int e = 0; e < LAT + 4; e++) begin
      step();
      chk("s4_short_pos1", pos_edge[1], 0);
    end
    signal_in[1] = 1'b1;
    for (int e = 1; e <= LAT + 2; e++) begin
      step();
      if (e == 5) signal_in[1] = 1'b0;
      chk("s4_long_pos1", pos_edge[1], (e == LAT));
    end
    repeat (LAT + 4) step();
`endif

    // Reset with all inputs high, then a reset that truncates the pulse.
    signal_in = 8'hFF;
    do_reset(3);
    chk("s5_rst_zero", {pos_edge, event_o, status_o, ovf_o}, 0);
    rst = 1'b0;
    for (int e = 1; e <= LAT; e++) begin
      step();
      chk("s5_pos_ff", pos_edge, (e == LAT) ? 8'hFF : 8'h00);
    end
    do_reset(2);
    chk("s5_truncate", pos_edge, 0);
    rst = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      step();
      chk("s5_pos_ff2", pos_edge, (e == LAT) ? 8'hFF : 8'h00);
    end
    signal_in = '0;
    repeat (LAT + 2) step();

    // Random traffic.
    irq_en_i = 8'hFF;
    for (int n = 0; n < 900; n++) begin
      mask = '0;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) mask[b] = 1'b1;
      signal_in = signal_in ^ mask;
      if ($urandom_range(0, 19) == 0) mode_i = 16'($urandom);
      if ($urandom_range(0, 19) == 0) irq_en_i = 8'($urandom);
      clr_i = '0;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 9) == 0) clr_i[b] = 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2);
        rst = 1'b0;
      end
      step();
    end
    clr_i = '0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
